fec23_dec: RTL and testbench

FEC23_DEC -- requirements
Module: fec23_dec

---
 rtl/fec23_pkg.sv | 46 ++++
 rtl/fec23_dec_if.sv | 36 +++
 rtl/fec23_synd_lut.sv | 34 +++
 rtl/fec23_dec.sv | 175 +++++++++++++++++
 tb/tb_fec23_dec.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fec23_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fec23_pkg
//  Description : Shared constants, FSM state type and GF(2) helpers for the
//                (15,10) shortened Hamming decoder, g(D) = D^5+D^4+D^2+1.
//  Revision    : 1.0  initial release
// ============================================================================
package fec23_pkg;

    localparam int         FEC23_N      = 15;
    localparam int         FEC23_K      = 10;
    // Low-order taps of g(D); the D^5 term is implicit in the shift-out.
    localparam logic [4:0] FEC23_G_TAPS = 5'b10101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } fec23_state_t;

    // Multiply a residue by x modulo g.
    function automatic logic [4:0] fec23_mul_x(input logic [4:0] i_s);
        return {i_s[3:0], 1'b0} ^ (i_s[4] ? FEC23_G_TAPS : 5'b00000);
    endfunction

    // One syndrome-LFSR step with the received bit injected at the top:
    // fb = s[4]^bit; s <= {fb^s[3], s[2], fb^s[1], s[0], fb}.
    function automatic logic [4:0] fec23_lfsr_step(input logic [4:0] i_s, input logic i_bit);
        logic w_fb;
        w_fb = i_s[4] ^ i_bit;
        return {i_s[3:0], 1'b0} ^ (w_fb ? FEC23_G_TAPS : 5'b00000);
    endfunction

    // Top injection leaves x^5*r(x) mod g in the LFSR. Because x^15 = 1 mod g,
    // ten further multiplications by x recover the plain remainder r(x) mod g,
    // which is the syndrome the single-error table is expressed in.
    function automatic logic [4:0] fec23_to_rem(input logic [4:0] i_s);
        logic [4:0] w_r;
        w_r = i_s;
        for (int i = 0; i < FEC23_N - 5; i++) begin
            w_r = fec23_mul_x(w_r);
        end
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fec23_dec_if.sv
`default_nettype none
// ============================================================================
//  Module      : fec23_dec_if
//  Description : Serial-in / decoded-word-out bundle of the FEC 2/3 decoder.
//                master : bit source / result sink (drives the strobes)
//                slave  : decoder (drives dout, flags, syndrome)
//  Ports       : loadini_p, datvalid_p, shift_in, fec_datin  (master -> slave)
//                dout[9:0], dout_valid, err_corr, err_uncorr,
//                syndrome[4:0]                              (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface fec23_dec_if;
    import fec23_pkg::*;

    logic               loadini_p;
    logic               datvalid_p;
    logic               shift_in;
    logic               fec_datin;
    logic [FEC23_K-1:0] dout;
    logic               dout_valid;
    logic               err_corr;
    logic               err_uncorr;
    logic [4:0]         syndrome;

    modport master (
        output loadini_p, datvalid_p, shift_in, fec_datin,
        input  dout, dout_valid, err_corr, err_uncorr, syndrome
    );

    modport slave (
        input  loadini_p, datvalid_p, shift_in, fec_datin,
        output dout, dout_valid, err_corr, err_uncorr, syndrome
    );

endinterface
`default_nettype wire

// File: rtl/fec23_synd_lut.sv
`default_nettype none
// ============================================================================
//  Module      : fec23_synd_lut
//  Description : Combinational single-error locator. Maps a syndrome to the
//                codeword index k whose error pattern gives S_k = x^(14-k)
//                mod g. The table is built from FEC23_G_TAPS at elaboration.
//  Ports       : i_syndrome[4:0] in  ; o_hit out ; o_pos[3:0] out
//  Revision    : 1.0  initial release
// ============================================================================
module fec23_synd_lut
    import fec23_pkg::*;
(
    input  wire logic [4:0] i_syndrome,
    output logic            o_hit,
    output logic [3:0]      o_pos
);

    always_comb begin
        logic [4:0] w_pow;
        o_hit = 1'b0;
        o_pos = 4'd0;
        // Walk k = 14 down to 0 while w_pow steps through x^0, x^1, ...
        w_pow = 5'b00001;
        for (int k = FEC23_N - 1; k >= 0; k--) begin
            if (i_syndrome == w_pow) begin
                o_hit = 1'b1;
                o_pos = 4'(k);
            end
            w_pow = fec23_mul_x(w_pow);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fec23_dec.sv
`default_nettype none
// ============================================================================
//  Module      : fec23_dec
//  Description : Serial (15,10) shortened Hamming decoder. Collects 15 bits
//                (10 info, 5 parity) into a syndrome LFSR, corrects a single
//                error and presents the info word one clock after the last
//                bit. Blocks run back to back; loadini_p re-aligns.
//  Ports       : clk_6M            in   block clock
//                rst               in   asynchronous active-high reset
//                bus               slave modport of fec23_dec_if
//                corr_cnt          out  corrected-block count (stats build)
//                uncorr_cnt        out  uncorrectable-block count (stats build)
//  Config      : FEC23_DEC_STATS_EN - when defined, adds the saturating
//                statistics counters and their ports.
//  Revision    : 1.0  initial release
// ============================================================================
module fec23_dec
    import fec23_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic       clk_6M,
    input  wire logic       rst,
    fec23_dec_if.slave      bus
`ifdef FEC23_DEC_STATS_EN
    ,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`endif
);

    fec23_state_t       r_state;
    fec23_state_t       w_state_nxt;
    logic               w_accept;

    logic [3:0]         r_cnt;
    logic [4:0]         r_lfsr;
    logic [FEC23_K-1:0] r_buf;

    logic [FEC23_K-1:0] r_dout;
    logic               r_dout_valid;
    logic               r_err_corr;
    logic               r_err_uncorr;
    logic [4:0]         r_syndrome;

    logic               w_last;
    logic [4:0]         w_lfsr_nxt;
    logic [4:0]         w_syn;
    logic               w_hit;
    logic [3:0]         w_pos;
    logic               w_uncorr;
    logic [FEC23_K-1:0] w_flip;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.loadini_p) begin
                    w_state_nxt = ST_RX;
                end
            end
            ST_RX: begin
                // A coincident loadini_p wins and the bit is dropped.
                w_accept = bus.shift_in & bus.datvalid_p & ~bus.loadini_p;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- decode datapath
    assign w_last     = w_accept && (r_cnt == 4'(FEC23_N - 1));
    assign w_lfsr_nxt = fec23_lfsr_step(r_lfsr, bus.fec_datin);
    assign w_syn      = fec23_to_rem(w_lfsr_nxt);

    fec23_synd_lut u_synd_lut (
        .i_syndrome (w_syn),
        .o_hit      (w_hit),
        .o_pos      (w_pos)
    );

    assign w_uncorr = (w_syn != 5'd0) && !w_hit;
    // Parity-bit errors (k >= 10) are flagged but leave the info word alone.
    assign w_flip   = (w_hit && (w_pos < 4'(FEC23_K)))
                    ? ({{(FEC23_K-1){1'b0}}, 1'b1} << w_pos)
                    : '0;

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_lfsr <= 5'd0;
            r_buf  <= '0;
        end else if (bus.loadini_p) begin
            r_cnt  <= 4'd0;
            r_lfsr <= 5'd0;
        end else if (w_accept) begin
            if (r_cnt < 4'(FEC23_K)) begin
                r_buf[r_cnt] <= bus.fec_datin;
            end
            if (w_last) begin
                r_cnt  <= 4'd0;
                r_lfsr <= 5'd0;
            end else begin
                r_cnt  <= r_cnt + 4'd1;
                r_lfsr <= w_lfsr_nxt;
            end
        end
    end

    // The last bit is parity, so r_buf already holds the complete info word.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_err_corr   <= 1'b0;
            r_err_uncorr <= 1'b0;
            r_syndrome   <= 5'd0;
        end else begin
            r_dout_valid <= w_last;
            if (w_last) begin
                r_dout       <= r_buf ^ w_flip;
                r_err_corr   <= w_hit;
                r_err_uncorr <= w_uncorr;
                r_syndrome   <= w_syn;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.err_corr   = r_err_corr;
    assign bus.err_uncorr = r_err_uncorr;
    assign bus.syndrome   = r_syndrome;

    // ------------------------------------------------------------ statistics
`ifdef FEC23_DEC_STATS_EN
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    // Counted on the same edge that raises dout_valid; saturating.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_last) begin
            if (w_hit && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (w_uncorr && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
            end
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    // CNT_W only sizes the statistics counters, which this build omits.
    if (CNT_W < 1) begin : g_no_stats
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fec23_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fec23_dec
//  Description : Scoreboard bench for fec23_dec. Stimulus encodes words with a
//                polynomial-division reference model, injects errors and
//                queues the expected decode; a negedge monitor pops and
//                compares on every dout_valid and checks output hold.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fec23_dec;
    import fec23_pkg::*;

`ifdef FEC23_DEC_STATS_EN
    localparam int c_cnt_w = 2;
`else
    localparam int c_cnt_w = 8;
`endif

    typedef struct {
        logic [9:0] dout;
        logic [4:0] syn;
        logic       corr;
        logic       uncorr;
    } exp_t;

    logic clk_6M = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_6M = ~clk_6M;

    fec23_dec_if bus ();

`ifdef FEC23_DEC_STATS_EN
    logic [c_cnt_w-1:0] corr_cnt;
    logic [c_cnt_w-1:0] uncorr_cnt;
    fec23_dec #(.CNT_W(c_cnt_w)) u_dut (
        .clk_6M     (clk_6M),
        .rst        (rst),
        .bus        (bus),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );
`else
    fec23_dec #(.CNT_W(c_cnt_w)) u_dut (
        .clk_6M (clk_6M),
        .rst    (rst),
        .bus    (bus)
    );
`endif

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   dv_gap = 0;

    always @(posedge clk_6M) cyc++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------- reference model
    // Polynomial bit p holds the coefficient of x^p; codeword index i sits at x^(14-i).
    function automatic logic [4:0] poly_mod(input logic [14:0] v);
        logic [14:0] r;
        logic [14:0] g;
        r = v;
        g = 15'b110101;  // x^5+x^4+x^2+1
        for (int p = 14; p >= 5; p--) begin
            if (r[p]) r = r ^ (g << (p - 5));
        end
        return r[4:0];
    endfunction

    function automatic logic [14:0] to_poly(input logic [14:0] cw);
        logic [14:0] p;
        for (int i = 0; i < 15; i++) p[14-i] = cw[i];
        return p;
    endfunction

    function automatic logic [14:0] encode(input logic [9:0] m);
        logic [14:0] cw;
        logic [4:0]  rem;
        cw = 15'd0;
        cw[9:0] = m;
        rem = poly_mod(to_poly(cw));
        for (int j = 0; j < 5; j++) cw[10+j] = rem[4-j];
        return cw;
    endfunction

    function automatic exp_t model(input logic [14:0] cw);
        exp_t        e;
        logic [14:0] one;
        e.dout   = cw[9:0];
        e.syn    = poly_mod(to_poly(cw));
        e.corr   = 1'b0;
        e.uncorr = (e.syn != 5'd0);
        for (int k = 0; k < 15; k++) begin
            one = 15'd1 << (14 - k);
            if (e.syn != 5'd0 && poly_mod(one) == e.syn) begin
                e.corr   = 1'b1;
                e.uncorr = 1'b0;
                if (k < 10) e.dout[k] = ~e.dout[k];
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [9:0] d, input logic [4:0] s, input logic c, input logic u);
        exp_t e;
        e.dout = d; e.syn = s; e.corr = c; e.uncorr = u;
        return e;
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.datvalid_p = 1'b0; bus.shift_in = 1'b0; bus.loadini_p = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_load();
        bus.loadini_p = 1'b1; bus.datvalid_p = 1'b0;
        tick();
        bus.loadini_p = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic load);
        bus.datvalid_p = 1'b1; bus.shift_in = 1'b1; bus.fec_datin = b; bus.loadini_p = load;
        tick();
        bus.loadini_p = 1'b0;
    endtask

    // With gaps set, randomly insert cycles where the bit is not accepted.
    task automatic send_block(input logic [14:0] cw, input bit gaps, input exp_t e, input bit push);
        for (int i = 0; i < 15; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                bus.fec_datin  = 1'($urandom);
                bus.loadini_p  = 1'b0;
                bus.datvalid_p = 1'($urandom_range(1));
                bus.shift_in   = ~bus.datvalid_p;
                tick();
            end
            if (i == 14 && push) q.push_back(e);
            send_bit(cw[i], 1'b0);
        end
    endtask

    // ------------------------------------------------------------- monitor
    initial begin
        exp_t held;
        int   prev;
        int   exp_corr;
        int   exp_unc;
        int   sat;
        held = mk(10'd0, 5'd0, 1'b0, 1'b0);
        prev = 0; exp_corr = 0; exp_unc = 0;
        sat  = (1 << c_cnt_w) - 1;
        forever begin
            @(negedge clk_6M);
            if (rst) begin
                held = mk(10'd0, 5'd0, 1'b0, 1'b0);
                exp_corr = 0; exp_unc = 0;
                check("rst_dout_valid", 32'(bus.dout_valid), 0);
            end else if (bus.dout_valid) begin
                dv_gap = cyc - prev;
                prev   = cyc;
                check("dv_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    held = q.pop_front();
                    if (held.corr && exp_corr < sat) exp_corr++;
                    if (held.uncorr && exp_unc < sat) exp_unc++;
                end
            end
            check("dout",       32'(bus.dout),       32'(held.dout));
            check("syndrome",   32'(bus.syndrome),   32'(held.syn));
            check("err_corr",   32'(bus.err_corr),   32'(held.corr));
            check("err_uncorr", 32'(bus.err_uncorr), 32'(held.uncorr));
`ifdef FEC23_DEC_STATS_EN
            check("corr_cnt",   32'(corr_cnt),   32'(exp_corr));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
`endif
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [14:0] cw;
        bus.loadini_p = 1'b0; bus.datvalid_p = 1'b0; bus.shift_in = 1'b0; bus.fec_datin = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // Bits before any loadini_p are ignored in IDLE.
        for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
        idle(2);

        // All-zero codeword.
        pulse_load();
        send_block(15'd0, 1'b0, mk(10'h000, 5'b00000, 1'b0, 1'b0), 1'b1);
        idle(3);

        // Single error at bit 8, double error at bits 2 and 5, single at bit 13.
        cw = 15'd0; cw[8] = 1'b1;
        send_block(cw, 1'b0, mk(10'h000, 5'b11111, 1'b1, 1'b0), 1'b1);
        cw = 15'd0; cw[2] = 1'b1; cw[5] = 1'b1;
        send_block(cw, 1'b0, mk(10'h024, 5'b00101, 1'b0, 1'b1), 1'b1);
        cw = 15'd0; cw[13] = 1'b1;
        send_block(cw, 1'b0, mk(10'h000, 5'b00010, 1'b1, 1'b0), 1'b1);
        idle(3);

        // Golden loopback, two back-to-back blocks.
        pulse_load();
        send_block(encode(10'h3FF), 1'b0, mk(10'h3FF, 5'd0, 1'b0, 1'b0), 1'b1);
        send_block(encode(10'h155), 1'b0, mk(10'h155, 5'd0, 1'b0, 1'b0), 1'b1);
        idle(3);
        check("loopback_gap", 32'(dv_gap), 15);

        // loadini_p after 7 bits discards the partial block.
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0);
        pulse_load();
        send_block(encode(10'h2A7), 1'b0, mk(10'h2A7, 5'd0, 1'b0, 1'b0), 1'b1);
        idle(2);

        // Reset mid-block, then bits without loadini_p are ignored.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) send_bit(1'($urandom), 1'b0);
        idle(2);
        pulse_load();

`ifdef FEC23_DEC_STATS_EN
        // Five corrected blocks into a 2-bit counter saturate at 3.
        for (int b = 0; b < 5; b++) begin
            cw = encode(10'($urandom));
            cw[b] = ~cw[b];
            send_block(cw, 1'b0, model(cw), 1'b1);
        end
        idle(3);
        check("corr_cnt_sat", 32'(corr_cnt), 3);
`endif

        // Randomised blocks: 0-2 errors, idle gaps, aborted partial blocks.
        for (int b = 0; b < 40; b++) begin
            logic [9:0] m;
            int         n_err;
            int         part;
            m     = 10'($urandom);
            cw    = encode(m);
            n_err = $urandom_range(2);
            for (int e = 0; e < n_err; e++) cw[$urandom_range(14)] ^= 1'b1;
            if ($urandom_range(5) == 0) begin
                part = $urandom_range(13, 1);
                for (int i = 0; i < part; i++) send_bit(1'($urandom), 1'b0);
                if ($urandom_range(1) == 0) send_bit(1'($urandom), 1'b1);
                else pulse_load();
            end else if ($urandom_range(3) == 0) begin
                idle($urandom_range(3));
            end
            send_block(cw, 1'b1, model(cw), 1'b1);
        end
        idle(5);
        check("queue_drained", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
